// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel frame capture path.
//   PIX_DATA_W / PIX_N_PIX : default pixel width and pixels per frame
//   pixel_t / frame_t      : one pixel, and one frame (pixel 0 in the LSBs)
//   state_e                : capture FSM states
package pixel_pkg;

    localparam int PIX_DATA_W = 8;
    localparam int PIX_N_PIX  = 4;

    typedef logic [PIX_DATA_W-1:0] pixel_t;
    typedef pixel_t [PIX_N_PIX-1:0] frame_t;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_e;

endpackage

// File: rtl/pixel_out_buffer.sv
// Single-entry valid/ready holding register for completed frames.
//   clk, reset_n : clock and asynchronous active-low reset
//   load         : write load_data this cycle; only asserted while free is high
//   load_data    : frame to hold
//   ready        : downstream accepts the held frame
//   valid, data  : held frame and its valid flag
//   free         : the buffer can take a load this cycle
//
// Handshake: a transfer occurs on any cycle where valid && ready. data is held
// constant while valid && !ready. The slot frees up in the same cycle it is
// drained, so a load and a transfer can coincide; valid then stays high and
// data switches to the new frame.
module pixel_out_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         free
);

    assign free = !valid || ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_frame_capture.sv
// Reassembles the serial pixel stream from the readout MUX into frame words.
//   clk, reset_n          : clock and asynchronous active-low reset
//   pix_valid/data/sel    : incoming pixel and its index (no backpressure)
//   frame_valid/ready/data: completed frame, valid/ready handshake
//   seq_err               : one-cycle pulse after an out-of-order index
//   overflow, clr_ovf     : sticky dropped-frame flag and its clear
//   frame_cnt             : frames handed off downstream, wrapping
//   dbg_state             : current capture FSM state
module pixel_frame_capture
    import pixel_pkg::*;
#(
    parameter int DATA_W = PIX_DATA_W,
    parameter int N_PIX  = PIX_N_PIX,
    parameter int SEL_W  = $clog2(N_PIX),
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pix_valid,
    input  logic [DATA_W-1:0]       pix_data,
    input  logic [SEL_W-1:0]        pix_sel,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [N_PIX*DATA_W-1:0] frame_data,
    output logic                    seq_err,
    output logic                    overflow,
    input  logic                    clr_ovf,
    output logic [CNT_W-1:0]        frame_cnt,
    output state_e                  dbg_state
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_PIX - 1);

    state_e                         state;
    logic [SEL_W-1:0]               exp_idx;
    logic [N_PIX-1:0][DATA_W-1:0]   cap_buf;
    logic [N_PIX-1:0][DATA_W-1:0]   merged;

    logic in_order;
    logic restart;
    logic bad;
    logic complete;
    logic store;
    logic out_free;
    logic out_load;

    // exp_idx is 0 whenever the FSM is IDLE, so one compare covers both the
    // "first pixel" check in IDLE and the in-sequence check in CAPTURE.
    assign in_order = pix_valid && (pix_sel == exp_idx);
    assign bad      = pix_valid && !in_order;
    // An out-of-order sel 0 is kept as the start of a fresh frame.
    assign restart  = bad && (pix_sel == '0);
    assign complete = in_order && (state == CAPTURE) && (pix_sel == LAST_IDX);
    assign store    = in_order || restart;
    assign out_load = complete && out_free;

    // The last pixel is handed off in the cycle it arrives, so the output
    // buffer takes the capture buffer with that pixel spliced in.
    always_comb begin
        merged          = cap_buf;
        merged[pix_sel] = pix_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            exp_idx   <= '0;
            cap_buf   <= '0;
            seq_err   <= 1'b0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            seq_err <= bad;

            if (store) begin
                cap_buf[pix_sel] <= pix_data;
            end

            if (complete) begin
                state   <= IDLE;
                exp_idx <= '0;
            end else if (in_order) begin
                state   <= CAPTURE;
                exp_idx <= exp_idx + 1'b1;
            end else if (restart) begin
                state   <= CAPTURE;
                exp_idx <= SEL_W'(1);
            end else if (bad) begin
                state   <= IDLE;
                exp_idx <= '0;
            end

            // Set has priority over a same-cycle clear.
            if (complete && !out_free) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            if (frame_valid && frame_ready) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    pixel_out_buffer #(
        .W(N_PIX * DATA_W)
    ) u_out_buffer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (out_load),
        .load_data(merged),
        .ready    (frame_ready),
        .valid    (frame_valid),
        .data     (frame_data),
        .free     (out_free)
    );

    assign dbg_state = state;

endmodule

// File: tb/tb_pixel_frame_capture.sv
module tb_pixel_frame_capture;
    import pixel_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic [1:0]  pix_sel;
    logic        frame_valid;
    logic        frame_ready;
    logic [31:0] frame_data;
    logic        seq_err;
    logic        overflow;
    logic        clr_ovf;
    logic [7:0]  frame_cnt;
    state_e      dbg_state;

    int n_asserts;
    int n_fail;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    pixel_frame_capture dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_sel    (pix_sel),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data (frame_data),
        .seq_err    (seq_err),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .frame_cnt  (frame_cnt),
        .dbg_state  (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drivers: called at a negedge, return at the next negedge
    task automatic pix(input logic [1:0] sel, input logic [7:0] data);
        pix_valid = 1'b1;
        pix_sel   = sel;
        pix_data  = data;
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_asserts   = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = '0;
        pix_sel     = '0;
        frame_ready = 1'b1;
        clr_ovf     = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", frame_valid, 1'b0);
        chk("rst_data", frame_data, 32'h0);
        chk("rst_seq", seq_err, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_cnt", frame_cnt, 8'd0);
        chk("rst_state", dbg_state, IDLE);
        reset_n = 1'b1;
        idle();

        // in-order frame, downstream always ready
        pix(2'd0, 8'h11);
        chk("t1_state", dbg_state, CAPTURE);
        pix(2'd1, 8'h22);
        pix(2'd2, 8'h33);
        chk("t1_novalid", frame_valid, 1'b0);
        pix(2'd3, 8'h44);
        chk("t1_valid", frame_valid, 1'b1);
        chk("t1_data", frame_data, 32'h44332211);
        chk("t1_state_idle", dbg_state, IDLE);
        chk("t1_noerr", seq_err, 1'b0);
        idle();
        chk("t1_valid_drop", frame_valid, 1'b0);
        chk("t1_cnt", frame_cnt, 8'd1);

        // two frames while stalled: second dropped
        frame_ready = 1'b0;
        pix(2'd0, 8'h01);
        pix(2'd1, 8'h02);
        pix(2'd2, 8'h03);
        pix(2'd3, 8'h04);
        chk("t2_valid", frame_valid, 1'b1);
        chk("t2_data", frame_data, 32'h04030201);
        pix(2'd0, 8'h05);
        pix(2'd1, 8'h06);
        chk("t2_hold_mid", frame_data, 32'h04030201);
        pix(2'd2, 8'h07);
        chk("t2_ovf_pre", overflow, 1'b0);
        pix(2'd3, 8'h08);
        chk("t2_ovf", overflow, 1'b1);
        chk("t2_hold", frame_data, 32'h04030201);
        chk("t2_hold_valid", frame_valid, 1'b1);
        chk("t2_cnt_stall", frame_cnt, 8'd1);
        frame_ready = 1'b1;
        idle();
        chk("t2_drain_valid", frame_valid, 1'b0);
        chk("t2_drain_cnt", frame_cnt, 8'd2);
        chk("t2_ovf_sticky", overflow, 1'b1);
        clr_ovf = 1'b1;
        idle();
        clr_ovf = 1'b0;
        chk("t2_ovf_clr", overflow, 1'b0);

        // sel 0,1,3 -> error, nothing delivered; then a clean frame
        pix(2'd0, 8'h10);
        pix(2'd1, 8'h11);
        chk("t3_noerr", seq_err, 1'b0);
        pix(2'd3, 8'h13);
        chk("t3_err", seq_err, 1'b1);
        chk("t3_state", dbg_state, IDLE);
        chk("t3_novalid", frame_valid, 1'b0);
        idle();
        chk("t3_err_pulse", seq_err, 1'b0);
        chk("t3_novalid2", frame_valid, 1'b0);
        pix(2'd0, 8'hA0);
        pix(2'd1, 8'hA1);
        pix(2'd2, 8'hA2);
        pix(2'd3, 8'hA3);
        chk("t3_valid", frame_valid, 1'b1);
        chk("t3_data", frame_data, 32'hA3A2A1A0);
        idle();
        chk("t3_cnt", frame_cnt, 8'd3);

        // sel 0,1,0,1,2,3 -> restart from second sel 0
        pix(2'd0, 8'hB0);
        pix(2'd1, 8'hB1);
        pix(2'd0, 8'hC0);
        chk("t4_err", seq_err, 1'b1);
        chk("t4_state", dbg_state, CAPTURE);
        pix(2'd1, 8'hC1);
        chk("t4_err_pulse", seq_err, 1'b0);
        pix(2'd2, 8'hC2);
        pix(2'd3, 8'hC3);
        chk("t4_valid", frame_valid, 1'b1);
        chk("t4_data", frame_data, 32'hC3C2C1C0);
        idle();
        chk("t4_cnt", frame_cnt, 8'd4);

        // completion in the same cycle as a transfer
        frame_ready = 1'b0;
        pix(2'd0, 8'hD0);
        pix(2'd1, 8'hD1);
        pix(2'd2, 8'hD2);
        pix(2'd3, 8'hD3);
        chk("t5_first", frame_data, 32'hD3D2D1D0);
        pix(2'd0, 8'hE0);
        pix(2'd1, 8'hE1);
        pix(2'd2, 8'hE2);
        frame_ready = 1'b1;
        pix(2'd3, 8'hE3);
        chk("t5_valid", frame_valid, 1'b1);
        chk("t5_data", frame_data, 32'hE3E2E1E0);
        chk("t5_ovf", overflow, 1'b0);
        chk("t5_cnt", frame_cnt, 8'd5);
        idle();
        chk("t5_drain", frame_valid, 1'b0);
        chk("t5_cnt2", frame_cnt, 8'd6);

        // reset while a frame is held and another is partial
        frame_ready = 1'b0;
        pix(2'd0, 8'hF0);
        pix(2'd1, 8'hF1);
        pix(2'd2, 8'hF2);
        pix(2'd3, 8'hF3);
        pix(2'd0, 8'h90);
        pix(2'd1, 8'h91);
        chk("t6_pre_valid", frame_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", frame_valid, 1'b0);
        chk("t6_rst_data", frame_data, 32'h0);
        chk("t6_rst_cnt", frame_cnt, 8'd0);
        chk("t6_rst_ovf", overflow, 1'b0);
        chk("t6_rst_state", dbg_state, IDLE);
        @(negedge clk);
        reset_n = 1'b1;
        frame_ready = 1'b1;
        idle();
        chk("t6_no_err", seq_err, 1'b0);
        pix(2'd0, 8'h50);
        pix(2'd1, 8'h51);
        pix(2'd2, 8'h52);
        pix(2'd3, 8'h53);
        chk("t6_data", frame_data, 32'h53525150);
        chk("t6_no_err2", seq_err, 1'b0);
        idle();
        chk("t6_cnt", frame_cnt, 8'd1);

        // counter wrap: 255 more frames back to back
        for (int i = 0; i < 254; i++) begin
            for (int s = 0; s < 4; s++) begin
                pix(2'(s), 8'(i));
            end
        end
        idle();
        chk("t7_cnt255", frame_cnt, 8'd255);
        pix(2'd0, 8'h61);
        pix(2'd1, 8'h62);
        pix(2'd2, 8'h63);
        pix(2'd3, 8'h64);
        chk("t7_data", frame_data, 32'h64636261);
        idle();
        chk("t7_wrap", frame_cnt, 8'd0);
        chk("t7_ovf", overflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_frame_capture.md
Name: pixel_frame_capture

Overview:
- Receive side of the pixel readout path: consumes the serial stream of 8-bit pixel values produced by the pixel-array readout MUX and its select counter, and reassembles them into one parallel frame word.
- Double buffered: one capture buffer and one output buffer, so capture of frame N+1 overlaps with a downstream stall on frame N.
- Sits between the pixel-array readout and the downstream frame consumer (e.g. ADC post-processing or an output interface).

Parameters:
- DATA_W, 8, bits per pixel
- N_PIX, 4, pixels per frame; must be a power of 2 and at least 2
- SEL_W, $clog2(N_PIX), width of the pixel index
- CNT_W, 8, width of the delivered-frame counter

Ports:
- clk  input  1  single clock; all logic is on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- pix_valid  input  1  pix_data/pix_sel are valid this cycle
- pix_data  input  DATA_W  pixel value from the readout MUX
- pix_sel  input  SEL_W  index of this pixel, equal to the readout MUX select
- frame_valid  output  1  output buffer holds a complete frame
- frame_ready  input  1  downstream accepts the frame
- frame_data  output  N_PIX*DATA_W  pixel k is at bits [k*DATA_W +: DATA_W]; pixel 0 is in the LSBs
- seq_err  output  1  one-cycle pulse on an out-of-order index
- overflow  output  1  sticky: a completed frame was dropped
- clr_ovf  input  1  clears overflow
- frame_cnt  output  CNT_W  count of frames handed off downstream; wraps

Behaviour:
- Reset: the asynchronous reset_n low forces state to IDLE, exp_idx to 0, both buffers to 0, frame_valid 0, seq_err 0, overflow 0, frame_cnt 0.
- The input side has no backpressure. The block never stalls pix_valid. A frame is dropped instead.
- FSM states:
  - IDLE: pix_valid with pix_sel==0 stores the pixel in capture slot 0, sets exp_idx=1 and moves to CAPTURE. pix_valid with pix_sel!=0 is discarded, pulses seq_err and stays in IDLE.
  - CAPTURE: pix_valid with pix_sel==exp_idx stores the pixel in slot pix_sel and increments exp_idx. If pix_sel==N_PIX-1 the frame is complete: go to IDLE and reset exp_idx to 0.
  - CAPTURE, mismatch: pix_valid with pix_sel!=exp_idx pulses seq_err and discards the partial frame. If pix_sel==0, the pixel is stored as slot 0 of a new frame and exp_idx becomes 1. Otherwise the block returns to IDLE.
  - pix_valid low holds the state, with no timeout.
- Completion handoff, in the same cycle as the last pixel:
  - If the output buffer is free, the capture buffer with the last pixel merged in is copied to the output buffer, and frame_valid rises on the next cycle (latency 1 clk from the last accepted pixel).
  - The output buffer counts as free when frame_valid==0 or (frame_valid && frame_ready).
  - If the output buffer is not free, the new frame is dropped, overflow sets, and the output buffer is unchanged.
- Output handshake:
  - A transfer happens on a cycle with frame_valid && frame_ready. On that cycle frame_cnt increments, wrapping from 2^CNT_W-1 to 0.
  - frame_valid drops after a transfer unless a new frame is loaded in that same cycle; in that case it stays 1 with the new data.
  - frame_data must stay stable while frame_valid && !frame_ready.
- overflow: clr_ovf clears it. If set and clear happen in the same cycle, set wins.
- Reset asserted mid-capture or mid-stall: the partial frame and the held frame are lost, and no seq_err is raised after release.
- seq_err is registered: it is high for exactly the cycle after the offending pix_valid.

Decomposition:
- Shared package pixel_pkg holds:
  - the DATA_W and N_PIX defaults
  - the pixel typedef (logic [DATA_W-1:0])
  - the frame typedef (packed array of N_PIX pixels)
  - the FSM state enum {IDLE, CAPTURE}
- One natural sub-module, pixel_out_buffer: a single-entry valid/ready holding register with a load input and a busy/free output. The FSM, the index check and the capture buffer stay in the top module.

Test Plan:
- In-order frame 0x11,0x22,0x33,0x44 on sel 0..3 with frame_ready=1 -> frame_valid for 1 cycle, one clk after sel 3; frame_data=0x44332211; frame_cnt=1.
- Two back-to-back frames with frame_ready=0 throughout -> first frame held stable, second frame dropped, overflow=1. Then frame_ready=1 -> first frame delivered. Then clr_ovf=1 -> overflow=0.
- Sequence sel 0,1,3 -> seq_err pulses once and nothing is delivered. Then sel 0,1,2,3 with 0xA0..0xA3 -> frame_data=0xA3A2A1A0.
- Sequence sel 0,1,0,1,2,3 -> one seq_err, and the frame is built from the second sel-0 pixel onward.
- Last pixel completes in the same cycle as a frame_valid&&frame_ready transfer -> frame_valid stays 1 with the new data, overflow stays 0, frame_cnt increments by 1.
- reset_n pulsed low mid-capture, and separately 256 delivered frames -> all outputs return to 0; frame_cnt wraps 255->0.
